lsu_controller: RTL
===================

LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles spent in REQ plus WAIT.
REQ-004 The block SHALL have a single clock and an asynchronous active-high reset, ports listed first below.
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous active-high reset
- load_i  input  1  decoded load for the current instruction
- store_i  input  1  decoded store for the current instruction
- fun3_i  input  3  funct3 of the current instruction
- addr_i  input  ADDR_WIDTH  effective byte address from the ALU
- wdata_i  input  DATA_WIDTH  rs2 store data
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
- mem_wdata_o  output  DATA_WIDTH  lane-positioned write data
- mem_mask_o  output  4  byte-enable mask
- mem_gnt_i  input  1  memory accepts the request
- mem_rvalid_i  input  1  read data valid
- mem_rdata_i  input  DATA_WIDTH  read data
- stall_o  output  1  hold the PC and instruction
- done_o  output  1  access complete; one-cycle pulse
- rdata_o  output  DATA_WIDTH  extended load result, valid with done_o
- err_o  output  1  access failed; valid with done_o

Function
REQ-005 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-006 In IDLE, when load_i or store_i is 1, the block SHALL capture fun3_i, addr_i and wdata_i, assert stall_o combinationally in the same cycle, and go to REQ.
REQ-007 In REQ, mem_req_o SHALL be 1 and its outputs SHALL be stable until mem_gnt_i; on gnt a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-008 In WAIT, the block SHALL latch the extended data on mem_rvalid_i and go to DONE; an rvalid in the same cycle as gnt SHALL be accepted.
REQ-009 In DONE, done_o SHALL be 1 and stall_o SHALL be 0 for exactly one cycle, after which the FSM SHALL return to IDLE; stall_o SHALL be 1 in REQ and WAIT.
REQ-010 Minimum latency: store 2 cycles and load 3 cycles from capture to done_o.
REQ-011 Store formatting SHALL be: SB mask = 1<<addr[1:0], with the byte replicated; SH mask = 0011 or 1100 by addr[1], with the half replicated; SW mask = 1111.
REQ-012 Loads SHALL be: LB/LH sign-extended; LBU/LHU zero-extended; LW unmodified; the lane is selected by addr[1:0].
REQ-013 For an illegal fun3 (load 011/110/111, store >010) or load_i and store_i both 1, the block SHALL make no memory request and go to DONE with err_o=1.
REQ-014 A cycle counter SHALL run in REQ and WAIT; reaching TIMEOUT_CYCLES-1 without completion SHALL drop mem_req_o and go to DONE with err_o=1 and rdata_o=0.
REQ-015 mem_rvalid_i and mem_gnt_i SHALL be ignored in IDLE and DONE.

Reset
REQ-016 rst SHALL force IDLE immediately, including mid-access, with the counter at 0 and mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mask_o, stall_o, done_o, rdata_o and err_o all 0.

Configuration
REQ-017 With MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL make no request and go to DONE with err_o=1.
REQ-018 Without MISALIGN_TRAP_EN, the block SHALL ignore the offending low address bits: a half uses addr[1] and a word uses lane 0; err_o SHALL then come only from illegal fun3 or timeout.

Structure
REQ-019 Package rv32i_pkg SHALL hold the lsu_state_e enum, the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the mask constants.
REQ-020 Sub-module lsu_align SHALL be purely combinational: store mask/data lane placement and load lane extraction/extension.

Verification
REQ-021 SB addr=0x1003, wdata=0x000000A5, gnt in the first REQ cycle -> mask=1000, wdata=0xA5A5A5A5, addr=0x1000, done on cycle 2.
REQ-022 LB addr=0x2001, rdata=0x00008000 with rvalid one cycle after gnt -> rdata_o=0xFFFFFF80, err_o=0; LBU at the same address -> 0x00000080.
REQ-023 LW addr=0x3002 -> with MISALIGN_TRAP_EN: no mem_req, err_o=1 at done; without it: access at 0x3000 with mask 1111.
REQ-024 Load with gnt held 0 for 16 cycles -> mem_req_o drops, done_o=1 with err_o=1, and a later rvalid is ignored.
REQ-025 rst asserted in WAIT -> all outputs 0 in the same cycle; a new LW after release completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Purpose  : Shared load/store unit types: FSM state enum, funct3 codes,
//             byte-enable masks and the funct3 legality helper.
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] c_lb  = 3'b000;
    localparam logic [2:0] c_lh  = 3'b001;
    localparam logic [2:0] c_lw  = 3'b010;
    localparam logic [2:0] c_lbu = 3'b100;
    localparam logic [2:0] c_lhu = 3'b101;
    localparam logic [2:0] c_sb  = 3'b000;
    localparam logic [2:0] c_sh  = 3'b001;
    localparam logic [2:0] c_sw  = 3'b010;

    localparam logic [3:0] c_mask_none    = 4'b0000;
    localparam logic [3:0] c_mask_byte0   = 4'b0001;
    localparam logic [3:0] c_mask_lo_half = 4'b0011;
    localparam logic [3:0] c_mask_hi_half = 4'b1100;
    localparam logic [3:0] c_mask_word    = 4'b1111;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3 inside {c_sb, c_sh, c_sw};
        return f3 inside {c_lb, c_lh, c_lw, c_lbu, c_lhu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic: store mask/data placement and load
//             lane extraction with sign/zero extension (32-bit lanes).
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_fun3,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [3:0]            o_mask,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // A half always uses addr[1]; the low bit is ignored when misaligned.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_mask  = c_mask_none;
        o_wdata = i_wdata;
        case (i_fun3[1:0])
            2'b00: begin
                o_mask  = c_mask_byte0 << i_addr_lo;
                o_wdata = {(DATA_WIDTH/8){i_wdata[7:0]}};
            end
            2'b01: begin
                o_mask  = i_addr_lo[1] ? c_mask_hi_half : c_mask_lo_half;
                o_wdata = {(DATA_WIDTH/16){i_wdata[15:0]}};
            end
            2'b10:   o_mask = c_mask_word;
            default: o_mask = c_mask_none;
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_fun3)
            c_lb:    o_rdata = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_lh:    o_rdata = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            c_lw:    o_rdata = i_rdata;
            c_lbu:   o_rdata = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_lhu:   o_rdata = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: o_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_controller
//  Purpose  : Load/store unit FSM (IDLE/REQ/WAIT/DONE) with timeout and
//             illegal-access reporting. Optional MISALIGN_TRAP_EN rejects
//             misaligned half/word accesses instead of ignoring low bits.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_controller
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [2:0]            fun3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_mask_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam logic [1:0] c_st_idle = LSU_IDLE;
    localparam logic [1:0] c_st_req  = LSU_REQ;
    localparam logic [1:0] c_st_wait = LSU_WAIT;
    localparam logic [1:0] c_st_done = LSU_DONE;

    localparam int              c_cnt_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [1:0]            r_state;
    logic [2:0]            r_fun3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_store;
    logic                  r_err;
    logic                  r_have_data;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_start;
    logic                  w_misalign;
    logic                  w_reject;
    logic                  w_in_req;
    logic                  w_in_done;
    logic [3:0]            w_mask;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_start = load_i | store_i;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((fun3_i[1:0] == 2'b01) &  addr_i[0]) |
                        ((fun3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = (load_i & store_i) | ~f3_legal(store_i, fun3_i) | w_misalign;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .i_fun3    (r_fun3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rdata_i),
        .o_mask    (w_mask),
        .o_wdata   (w_st_data),
        .o_rdata   (w_ld_data)
    );

    // Read data arriving together with the grant is held in r_rdata and the
    // FSM still passes through WAIT, keeping the load latency uniform.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_fun3      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_store     <= 1'b0;
            r_err       <= 1'b0;
            r_have_data <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_fun3      <= fun3_i;
                        r_addr      <= addr_i;
                        r_wdata     <= wdata_i;
                        r_store     <= store_i;
                        r_rdata     <= '0;
                        r_have_data <= 1'b0;
                        r_cnt       <= '0;
                        r_err       <= w_reject;
                        r_state     <= w_reject ? c_st_done : c_st_req;
                    end
                end
                c_st_req: begin
                    if (mem_gnt_i && r_store) begin
                        r_state <= c_st_done;
                    end else if (mem_gnt_i && mem_rvalid_i) begin
                        r_rdata     <= w_ld_data;
                        r_have_data <= 1'b1;
                        r_cnt       <= r_cnt + c_cnt_one;
                        r_state     <= c_st_wait;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (mem_gnt_i)
                            r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (r_have_data || mem_rvalid_i) begin
                        if (!r_have_data)
                            r_rdata <= w_ld_data;
                        r_state <= c_st_done;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign w_in_req  = (r_state == c_st_req);
    assign w_in_done = (r_state == c_st_done);

    assign mem_req_o   = w_in_req;
    assign mem_we_o    = w_in_req & r_store;
    assign mem_addr_o  = w_in_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata_o = w_in_req ? w_st_data : '0;
    assign mem_mask_o  = w_in_req ? w_mask : c_mask_none;

    // The IDLE term is combinational so the pipeline freezes in the capture cycle.
    assign stall_o = ((r_state == c_st_idle) & w_start & ~rst) | w_in_req | (r_state == c_st_wait);
    assign done_o  = w_in_done;
    assign err_o   = w_in_done & r_err;
    assign rdata_o = w_in_done ? r_rdata : '0;

endmodule
`default_nettype wire
